// File: rtl/uart_parity_engine.sv
// uart_parity_engine
// Bit-serial parity accumulator shared by the UART TX and RX paths. Data bits are
// strobed in one at a time. The parity bit for the latched mode is presented once the
// latched data length is reached, and a received parity bit can be checked against it.
// Optional feature macro: UART_PARITY_ERRCNT_EN adds a saturating mismatch counter
// on the err_cnt port. Without the macro, that port and its counter are absent.
//
// Handshake: bit_valid, par_valid and frame_start are single-cycle strobes sampled on
// the rising clock edge. There is no back-pressure. A strobe that arrives in a state
// that cannot use it is dropped. par_ready is a level that stays high for the whole
// READY state.

module uart_parity_engine #(
    parameter int MAX_DATA_BITS = 9,
    parameter int MIN_DATA_BITS = 5,
    parameter int ERR_CNT_W     = 8,
    localparam int LW           = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    cfg_mode,
    input  logic [LW-1:0] cfg_data_len,
    input  logic          frame_start,
    input  logic          bit_valid,
    input  logic          bit_in,
    input  logic          par_valid,
    input  logic          par_in,
    input  logic          err_clr,
    output logic          par_ready,
    output logic          par_bit,
    output logic          par_err,
    output logic          par_err_sticky,
    output logic [LW-1:0] bit_cnt,
    output logic [1:0]    dbg_state
`ifdef UART_PARITY_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [LW-1:0] MIN_L = LW'(MIN_DATA_BITS);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_DATA_BITS);

    localparam logic [2:0] MODE_EVEN  = 3'b001;
    localparam logic [2:0] MODE_ODD   = 3'b010;
    localparam logic [2:0] MODE_MARK  = 3'b011;
    localparam logic [2:0] MODE_SPACE = 3'b100;

    state_t        r_state;
    logic [2:0]    r_mode;
    logic [LW-1:0] r_len;
    logic          r_acc;
    logic [LW-1:0] r_bit_cnt;
    logic          r_par_ready;
    logic          r_par_bit;
    logic          r_par_err;
    logic          r_par_err_sticky;

    logic [LW-1:0] w_len_clamped;
    logic          w_next_acc;
    logic [LW-1:0] w_next_cnt;
    logic          w_mode_none;
    logic          w_mismatch;

    // Parity bit for a mode and accumulated XOR. Codes 000 and 101-111 behave as "none".
    function automatic logic parity_out(input logic [2:0] mode, input logic acc);
        case (mode)
            MODE_EVEN:  parity_out = acc;
            MODE_ODD:   parity_out = ~acc;
            MODE_MARK:  parity_out = 1'b1;
            MODE_SPACE: parity_out = 1'b0;
            default:    parity_out = 1'b1;
        endcase
    endfunction

    // Clamp the requested length into the supported range before it is latched.
    always_comb begin
        w_len_clamped = cfg_data_len;
        if (cfg_data_len < MIN_L) begin
            w_len_clamped = MIN_L;
        end else if (cfg_data_len > MAX_L) begin
            w_len_clamped = MAX_L;
        end
    end

    assign w_next_acc  = r_acc ^ bit_in;
    assign w_next_cnt  = r_bit_cnt + 1'b1;
    assign w_mode_none = (r_mode == 3'b000) || (r_mode > MODE_SPACE);

    // A frame_start in READY abandons the frame, so it also suppresses the parity check.
    assign w_mismatch = (r_state == READY) && par_valid && !frame_start &&
                        !w_mode_none && (par_in != r_par_bit);

    // Frame FSM together with its accumulator, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_mode           <= 3'b000;
            r_len            <= MAX_L;
            r_acc            <= 1'b0;
            r_bit_cnt        <= '0;
            r_par_ready      <= 1'b0;
            r_par_bit        <= 1'b1;
            r_par_err        <= 1'b0;
            r_par_err_sticky <= 1'b0;
        end else begin
            r_par_err <= w_mismatch;
            // A mismatch in the same cycle as err_clr wins.
            if (w_mismatch) begin
                r_par_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_par_err_sticky <= 1'b0;
            end

            if (frame_start) begin
                // Restart from any state. A same-cycle data bit counts as bit 1.
                r_state     <= ACCUM;
                r_mode      <= cfg_mode;
                r_len       <= w_len_clamped;
                r_par_ready <= 1'b0;
                r_acc       <= bit_valid ? bit_in : 1'b0;
                r_bit_cnt   <= bit_valid ? LW'(1) : '0;
            end else begin
                case (r_state)
                    ACCUM: begin
                        if (bit_valid) begin
                            r_acc     <= w_next_acc;
                            r_bit_cnt <= w_next_cnt;
                            if (w_next_cnt == r_len) begin
                                r_state     <= READY;
                                r_par_ready <= 1'b1;
                                r_par_bit   <= parity_out(r_mode, w_next_acc);
                            end
                        end
                    end
                    READY: begin
                        if (par_valid) begin
                            r_state     <= IDLE;
                            r_par_ready <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign par_ready      = r_par_ready;
    assign par_bit        = r_par_bit;
    assign par_err        = r_par_err;
    assign par_err_sticky = r_par_err_sticky;
    assign bit_cnt        = r_bit_cnt;
    assign dbg_state      = r_state;

`ifdef UART_PARITY_ERRCNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating mismatch counter. A same-cycle mismatch beats err_clr and leaves a count of 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= w_mismatch ? ERR_CNT_W'(1) : '0;
        end else if (w_mismatch && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_err_cnt_w;
    assign w_unused_err_cnt_w = (ERR_CNT_W > 0);
`endif

endmodule
